// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the fetch-stage PC unit.
// Holds the default reset PC, the legal text window, the FSM state encoding,
// the instruction-word width and a helper that flags illegal fetch addresses.
package pc_fetch_ctrl_pkg;

  localparam int IW = 32;

  localparam logic [IW-1:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [IW-1:0] TEXT_LO_DEF  = 32'h0000_3000;
  localparam logic [IW-1:0] TEXT_HI_DEF  = 32'h0000_6FFC;

  // 2'd3 is unused; the FSM treats it like RUN so a corrupted state recovers.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HOLD      = 2'd1,
    HOLD_PEND = 2'd2
  } state_e;

  // Misaligned or outside the inclusive [lo, hi] text window.
  function automatic logic addr_bad(input logic [IW-1:0] a,
                                    input logic [IW-1:0] lo,
                                    input logic [IW-1:0] hi);
    return (a[1:0] != 2'b00) || (a < lo) || (a > hi);
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_next_pc_sel.sv
// Combinational next-PC priority mux.
// Ports:
//   pc_plus4     sequential successor of the current pc
//   pending      redirect target stored while stalled
//   state        current FSM state (selects pending in HOLD_PEND)
//   br_taken/br_target, jump/jump_target, jr/jr_target  live redirects
//   next_target  chosen next pc (also the value to latch as pending)
//   redir        any live redirect this cycle
module next_pc_sel
  import pc_fetch_ctrl_pkg::*;
(
  input  logic [IW-1:0] pc_plus4,
  input  logic [IW-1:0] pending,
  input  state_e        state,
  input  logic          br_taken,
  input  logic [IW-1:0] br_target,
  input  logic          jump,
  input  logic [IW-1:0] jump_target,
  input  logic          jr,
  input  logic [IW-1:0] jr_target,
  output logic [IW-1:0] next_target,
  output logic          redir
);

  assign redir = jr | jump | br_taken;

  // A live redirect always beats a stored one; jr > jump > branch.
  always_comb begin
    next_target = pc_plus4;
    if (jr)                      next_target = jr_target;
    else if (jump)               next_target = jump_target;
    else if (br_taken)           next_target = br_target;
    else if (state == HOLD_PEND) next_target = pending;
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage program-counter unit.
// Holds the architectural pc, advances it by 4 or redirects it, honours decode
// stalls and remembers a redirect that arrives while stalled.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   stall                 hold pc (hazard unit)
//   br_taken, br_target   taken conditional branch and its target
//   jump, jump_target     j/jal and its target
//   jr, jr_target         jr/jalr and the forwarded register value
//   pc, pc_plus4          current fetch address and its successor
//   fetch_valid           a new instruction is presented this cycle
//   addr_err              pc misaligned or outside the text window
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] TEXT_LO  = TEXT_LO_DEF,
  parameter logic [31:0] TEXT_HI  = TEXT_HI_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        addr_err
);

  state_e        state_q, state_d;
  logic [IW-1:0] pc_q, pc_d;
  logic [IW-1:0] pend_q, pend_d;
  logic          fv_q, fv_d;
  // Low until the first edge after reset release; that edge presents RESET_PC
  // without advancing.
  logic          started_q;

  logic [IW-1:0] next_target;
  logic          redir;

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign fetch_valid = fv_q;
  assign addr_err    = addr_bad(pc_q, TEXT_LO, TEXT_HI);

  next_pc_sel u_sel (
    .pc_plus4    (pc_plus4),
    .pending     (pend_q),
    .state       (state_q),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jump        (jump),
    .jump_target (jump_target),
    .jr          (jr),
    .jr_target   (jr_target),
    .next_target (next_target),
    .redir       (redir)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    fv_d    = 1'b1;
    if (!started_q) begin
      state_d = RUN;
    end else if (stall) begin
      fv_d = 1'b0;
      if (redir) begin
        // Last redirect seen during the stall wins.
        pend_d  = next_target;
        state_d = HOLD_PEND;
      end else if (state_q == HOLD_PEND) begin
        state_d = HOLD_PEND;
      end else begin
        state_d = HOLD;
      end
    end else begin
      pc_d    = next_target;
      pend_d  = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      pend_q    <= '0;
      fv_q      <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      fv_q      <= fv_d;
      started_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: a table of directed vectors, an async
// reset sequence and a randomized run checked against a behavioural model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] LO     = 32'h0000_3000;
  localparam logic [31:0] HI     = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, br_taken = 1'b0, jump = 1'b0, jr = 1'b0;
  logic [31:0] br_target = '0, jump_target = '0, jr_target = '0;
  logic [31:0] pc, pc_plus4;
  logic        fetch_valid, addr_err;

  int n_chk = 0;
  int n_err = 0;

  pc_fetch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jump        (jump),
    .jump_target (jump_target),
    .jr          (jr),
    .jr_target   (jr_target),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_valid (fetch_valid),
    .addr_err    (addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  logic        m_fv;
  bit          m_started;
  logic [31:0] m_pend[$];   // at most one stored redirect

  function automatic logic m_err(input logic [31:0] a);
    return (a % 4 != 0) || (a < LO) || (a > HI);
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_fv = 1'b0; m_started = 0; m_pend.delete();
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    bit          any;
    any = 1; tgt = '0;
    if (jr)            tgt = jr_target;
    else if (jump)     tgt = jump_target;
    else if (br_taken) tgt = br_target;
    else               any = 0;
    if (!m_started) begin
      m_started = 1; m_fv = 1'b1;
    end else if (stall) begin
      m_fv = 1'b0;
      if (any) begin m_pend.delete(); m_pend.push_back(tgt); end
    end else begin
      m_fv = 1'b1;
      if (any)                  m_pc = tgt;
      else if (m_pend.size > 0) m_pc = m_pend[0];
      else                      m_pc = m_pc + 32'd4;
      m_pend.delete();
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        s, b;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic        r;
    logic [31:0] rt;
    logic [31:0] epc;
    logic        efv;
    logic        eerr;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt,
                              input logic r, input logic [31:0] rt,
                              input logic [31:0] epc, input logic efv, input logic eerr);
    vec_t v;
    v.s = s; v.b = b; v.bt = bt; v.j = j; v.jt = jt; v.r = r; v.rt = rt;
    v.epc = epc; v.efv = efv; v.eerr = eerr;
    return v;
  endfunction

  // Called at a negedge; returns 1 time unit after the following posedge.
  task automatic drive_step(input vec_t v);
    stall = v.s; br_taken = v.b; br_target = v.bt;
    jump = v.j; jump_target = v.jt; jr = v.r; jr_target = v.rt;
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic vec_t idle(input logic [31:0] epc, input logic eerr);
    return mk(0, 0, 0, 0, 0, 0, 0, epc, 1, eerr);
  endfunction

  vec_t tbl[$];
  vec_t v;

  initial begin
    model_reset();
    // -------- reset state --------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", pc, RST_PC);
    chk("rst_fv", {31'b0, fetch_valid}, 32'd0);
    chk("rst_err", {31'b0, addr_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // -------- directed table --------
    tbl.push_back(idle(32'h3000, 0));                                 // first edge holds pc
    tbl.push_back(idle(32'h3004, 0));
    tbl.push_back(idle(32'h3008, 0));
    tbl.push_back(idle(32'h300C, 0));
    tbl.push_back(idle(32'h3010, 0));
    tbl.push_back(mk(0, 1, 32'h3040, 1, 32'h3100, 0, 0, 32'h3100, 1, 0));  // jump > br
    tbl.push_back(mk(0, 1, 32'h3040, 1, 32'h3100, 1, 32'h3200, 32'h3200, 1, 0)); // jr > all
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h3020, 32'h3020, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h3020, 0, 0));            // stall
    tbl.push_back(mk(1, 1, 32'h3080, 0, 0, 0, 0, 32'h3020, 0, 0));     // redirect latched
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h3020, 0, 0));
    tbl.push_back(idle(32'h3080, 0));                                 // pending taken
    tbl.push_back(idle(32'h3084, 0));
    tbl.push_back(mk(1, 1, 32'h3080, 0, 0, 0, 0, 32'h3084, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h3400, 0, 0, 32'h3400, 1, 0));     // live beats pending
    tbl.push_back(idle(32'h3404, 0));                                 // pending cleared
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h3002, 32'h3002, 1, 1));     // misaligned
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h7000, 32'h7000, 1, 1));     // above window
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 1));
    tbl.push_back(idle(32'h0000_0000, 1));                            // wrap
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h6FFC, 32'h6FFC, 1, 0));     // top of window
    tbl.push_back(idle(32'h7000, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h2FFC, 32'h2FFC, 1, 1));     // below window
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h3000, 32'h3000, 1, 0));     // bottom of window

    for (int i = 0; i < tbl.size(); i++) begin
      drive_step(tbl[i]);
      chk($sformatf("tbl%0d_pc", i), pc, tbl[i].epc);
      chk($sformatf("tbl%0d_pc4", i), pc_plus4, tbl[i].epc + 32'd4);
      chk($sformatf("tbl%0d_fv", i), {31'b0, fetch_valid}, {31'b0, tbl[i].efv});
      chk($sformatf("tbl%0d_err", i), {31'b0, addr_err}, {31'b0, tbl[i].eerr});
      @(negedge clk);
    end

    // -------- async reset while a redirect is pending --------
    drive_step(mk(1, 1, 32'h3500, 0, 0, 0, 0, 32'h3000, 0, 0));
    chk("pend_hold_pc", pc, 32'h3000);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_pc", pc, RST_PC);
    chk("arst_fv", {31'b0, fetch_valid}, 32'd0);
    @(negedge clk);
    stall = 1'b0; br_taken = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive_step(idle(0, 0));
    chk("arst_first_pc", pc, 32'h3000);
    chk("arst_first_fv", {31'b0, fetch_valid}, 32'd1);
    @(negedge clk);
    drive_step(idle(0, 0));
    chk("arst_no_stale", pc, 32'h3004);
    @(negedge clk);

    // -------- randomized run against the model --------
    for (int i = 0; i < 400; i++) begin
      v.s  = ($urandom_range(0, 9) < 3);
      v.b  = ($urandom_range(0, 9) < 2);
      v.j  = ($urandom_range(0, 9) < 1);
      v.r  = ($urandom_range(0, 9) < 1);
      v.bt = ($urandom_range(0, 7) == 0) ? $urandom() : LO + ($urandom_range(0, 4095) << 2);
      v.jt = ($urandom_range(0, 7) == 0) ? $urandom() : LO + ($urandom_range(0, 4095) << 2);
      v.rt = ($urandom_range(0, 7) == 0) ? $urandom() : LO + ($urandom_range(0, 4095) << 2);
      drive_step(v);
      chk("rnd_pc", pc, m_pc);
      chk("rnd_pc4", pc_plus4, m_pc + 32'd4);
      chk("rnd_fv", {31'b0, fetch_valid}, {31'b0, m_fv});
      chk("rnd_err", {31'b0, addr_err}, {31'b0, m_err(m_pc)});
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Fetch-stage program-counter unit. Holds the architectural PC and selects next PC from PC+4, the branch target (branch-target adder output, = offset<<2 + PC + 4), the jump target or the register-jump target.
- Honours decode stalls. A redirect that arrives while stalled is latched, not dropped.
- Drives the instruction-memory address and the PC fed back to the branch-target adder.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- TEXT_LO, 32'h0000_3000, lowest legal fetch address.
- TEXT_HI, 32'h0000_6FFC, highest legal fetch address.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- stall  in  1  hold PC; from hazard unit.
- br_taken  in  1  conditional branch resolved taken this cycle.
- br_target  in  32  branch-target adder output.
- jump  in  1  j/jal this cycle.
- jump_target  in  32  {PC+4[31:28], index, 2'b00}, formed upstream.
- jr  in  1  jr/jalr this cycle.
- jr_target  in  32  forwarded rs value.
- pc  out  32  current fetch address.
- pc_plus4  out  32  pc + 4, modulo 2^32.
- fetch_valid  out  1  new instruction presented this cycle.
- addr_err  out  1  current pc misaligned or outside [TEXT_LO, TEXT_HI].

Behaviour:
- Reset (async assert, sync release on next edge):
  - pc = RESET_PC, state = RUN, pending register cleared.
  - fetch_valid = 0, addr_err = 0.
  - First rising edge after rst_n rises: fetch_valid becomes 1; pc stays RESET_PC for that edge only.
- Live redirect: redir = jr | jump | br_taken. Target priority is jr > jump > br_taken; multiple asserts are legal and resolved by that priority.
- States, 2-bit encoding:
  - RUN: no stall, no pending redirect.
  - HOLD: stalled, nothing pending.
  - HOLD_PEND: stalled, pending redirect stored.
- Each edge, no reset:
  - stall=1, redir=0: pc held; fetch_valid=0. RUN→HOLD; HOLD_PEND stays (pending kept).
  - stall=1, redir=1: pc held; pending target ← live target (last wins); fetch_valid=0; →HOLD_PEND.
  - stall=0, redir=1: pc ← live target; pending cleared (live beats pending); fetch_valid=1; →RUN.
  - stall=0, redir=0, HOLD_PEND: pc ← pending target; pending cleared; fetch_valid=1; →RUN.
  - stall=0, redir=0, RUN/HOLD: pc ← pc+4; fetch_valid=1; →RUN.
- Latency:
  - Redirect is visible on pc one cycle after assertion when not stalled.
  - Pending redirect is visible one cycle after stall drops.
- Arithmetic and error flag:
  - pc+4 wraps 32'hFFFF_FFFC → 32'h0000_0000.
  - Targets are used unmodified: no masking, no realignment.
  - addr_err is combinational from the pc register: pc[1:0]!=0 or pc<TEXT_LO or pc>TEXT_HI. The unit keeps fetching; the exception path consumes addr_err.
- Reset asserted mid-stall or with a redirect pending: all state is discarded immediately and the reset values above apply.

Decomposition:
- Shared package holds:
  - RESET_PC, TEXT_LO, TEXT_HI defaults.
  - State encoding: RUN=2'd0, HOLD=2'd1, HOLD_PEND=2'd2; 2'd3 illegal, recovers to RUN.
  - Instruction-word width constant (32).
- One natural sub-module: next_pc_sel, a combinational priority mux. Inputs are pc_plus4, pending, the three live targets and state; outputs are next target and redir.
- Top level holds only registers and the FSM.

Test Plan:
- Reset/sequential: hold rst_n=0 3 cycles, release → pc=3000 and fetch_valid=0 in reset, then fetch_valid=1; pc runs 3000, 3004, 3008 on successive edges.
- Branch priority: at pc=3010 assert br_taken (br_target=3040) and jump (jump_target=3100) together → next pc=3100; assert all three with jr_target=3200 → next pc=3200.
- Redirect during stall: stall=1 for 3 cycles at pc=3020, br_taken with br_target=3080 on cycle 2 only → pc holds 3020, fetch_valid=0 for those 3 cycles; first unstalled edge → pc=3080, then 3084.
- Live beats pending: pending=3080 from stall; on the release cycle jump with jump_target=3400 → pc=3400; pending cleared, next pc=3404.
- Errors/wrap: jr_target=3002 → addr_err=1 with pc=3002; jr_target=7000 → addr_err=1; jr_target=FFFFFFFC then free-run → pc=00000000 with addr_err=1.
- Async reset: drop rst_n between edges while in HOLD_PEND → pc=3000 and fetch_valid=0 immediately; after release no stale redirect is taken, pc runs 3000, 3004.
